// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data SRAM (1-cycle read latency)
// between the pipeline memory stage (priority) and the loader/debug port.
// Optional build macro DMEM_ARB_FAIRNESS_EN adds a saturating starvation
// counter that forces a loader grant after STARVE_LIMIT denied cycles.
// Without the macro, the loader is served only in idle cycles with no m_req.
module dmem_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m_req_i,
    input  logic          m_we_i,
    input  logic [63:0]   m_addr_i,
    input  logic [63:0]   m_wdata_i,
    output logic [63:0]   m_rdata_o,
    output logic          m_stall_o,
    output logic          m_err_o,
    input  logic          l_valid_i,
    output logic          l_ready_o,
    input  logic          l_we_i,
    input  logic [AW-1:0] l_addr_i,
    input  logic [63:0]   l_wdata_i,
    output logic          l_rvalid_o,
    output logic [63:0]   l_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [63:0]   mem_wdata_o,
    input  logic [63:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P_RD = 2'd1,
        L_RD = 2'd2
    } state_e;

    // Loader addresses need a range check only when the SRAM is not a full power of two.
    localparam bit LADDR_CHK = (DEPTH < (1 << AW));

    state_e        state_q, state_d;
    logic          l_drop_q, l_drop_d;

    logic          m_addr_ok_s;
    logic          l_addr_ok_s;
    logic          forced_s;
    logic          grant_l_s;

    logic          mem_en_s, mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [63:0]   mem_wdata_s;
    logic          m_stall_s, m_err_s;
    logic [63:0]   m_rdata_s;
    logic          l_ready_s;
    logic          l_rvalid_s;
    logic [63:0]   l_rdata_s;

    assign m_addr_ok_s = (m_addr_i < 64'(DEPTH));
    assign l_addr_ok_s = !LADDR_CHK || (32'(l_addr_i) < 32'(DEPTH));

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q, starve_d;

    assign forced_s = (starve_q == CW'(STARVE_LIMIT));

    // Starvation count: clears on a grant or an idle loader, otherwise saturating increment.
    always_comb begin
        starve_d = starve_q;
        if (!l_valid_i || l_ready_s) begin
            starve_d = '0;
        end else if (forced_s) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // No fairness logic: the loader is never forced (limit is always positive).
    assign forced_s = (STARVE_LIMIT < 0);
`endif

    // Arbitration, SRAM command and next state; loader grant handled after the case.
    always_comb begin
        state_d     = state_q;
        l_drop_d    = l_drop_q;
        grant_l_s   = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 64'd0;
        m_stall_s   = 1'b0;
        m_err_s     = 1'b0;
        m_rdata_s   = 64'd0;
        l_ready_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_req_i && !m_addr_ok_s) begin
                    m_err_s = 1'b1;
                end else if (forced_s && l_valid_i) begin
                    grant_l_s = 1'b1;
                    m_stall_s = m_req_i;
                end else if (m_req_i) begin
                    mem_en_s    = 1'b1;
                    mem_we_s    = m_we_i;
                    mem_addr_s  = m_addr_i[AW-1:0];
                    mem_wdata_s = m_wdata_i;
                    if (m_we_i) begin
                        m_stall_s = 1'b0;
                    end else begin
                        m_stall_s = 1'b1;
                        state_d   = P_RD;
                    end
                end else if (l_valid_i) begin
                    grant_l_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            P_RD: begin
                m_rdata_s = mem_rdata_i;
                state_d   = IDLE;
            end
            L_RD: begin
                m_stall_s = m_req_i;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_l_s) begin
            l_ready_s = 1'b1;
            l_drop_d  = !l_addr_ok_s;
            if (l_addr_ok_s) begin
                mem_en_s    = 1'b1;
                mem_we_s    = l_we_i;
                mem_addr_s  = l_addr_i;
                mem_wdata_s = l_wdata_i;
            end else begin
                mem_en_s = 1'b0;
            end
            if (!l_we_i) begin
                state_d = L_RD;
            end else begin
                state_d = IDLE;
            end
        end else begin
            l_ready_s = 1'b0;
        end
    end

    // Loader response: a dropped (out-of-range) read still responds, with zero data.
    always_comb begin
        l_rvalid_s = (state_q == L_RD);
        if ((state_q == L_RD) && !l_drop_q) begin
            l_rdata_s = mem_rdata_i;
        end else begin
            l_rdata_s = 64'd0;
        end
    end

    // State and dropped-read flag registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            l_drop_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_drop_q <= l_drop_d;
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    assign mem_en_o    = rst_n & mem_en_s;
    assign mem_we_o    = rst_n & mem_we_s;
    assign mem_addr_o  = rst_n ? mem_addr_s  : '0;
    assign mem_wdata_o = rst_n ? mem_wdata_s : 64'd0;
    assign m_stall_o   = rst_n & m_stall_s;
    assign m_err_o     = rst_n & m_err_s;
    assign m_rdata_o   = rst_n ? m_rdata_s   : 64'd0;
    assign l_ready_o   = rst_n & l_ready_s;
    assign l_rvalid_o  = rst_n & l_rvalid_s;
    assign l_rdata_o   = rst_n ? l_rdata_s   : 64'd0;

endmodule
